clock_set_ctrl: RTL and testbench

CLOCK_SET_CTRL -- requirements
Module: clock_set_ctrl

---
 rtl/clock_set_ctrl_if.sv | 47 ++++
 rtl/clock_set_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_clock_set_ctrl.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/clock_set_ctrl_if.sv
// ---------------------------------------------------------------------------
// clock_set_ctrl_if
// Bundles the signals exchanged between the clock-setting controller and its
// surroundings (prescaler, buttons, time counter, display).
//
//   seconds_pulse_i      1 Hz level from the prescaler, rising edge = 1 s
//   mode/up/down_btn_i   debounced button levels, rising edge = one press
//   cur_*_i              live time from the time counter
//   tick_o               one-cycle second strobe to the time counter
//   load_o               one-cycle strobe, counter takes load_*_o
//   load_*_o             shadow time being edited
//   state_o              controller state encoding
//   blink_o              display blink enable for the field being edited
//
// Modports: slave  = the controller (consumes the *_i, drives the *_o)
//           master = the environment around the controller
// ---------------------------------------------------------------------------
interface clock_set_ctrl_if;
    logic       seconds_pulse_i;
    logic       mode_btn_i;
    logic       up_btn_i;
    logic       down_btn_i;
    logic [5:0] cur_seconds_i;
    logic [5:0] cur_minutes_i;
    logic [4:0] cur_hours_i;
    logic       tick_o;
    logic       load_o;
    logic [5:0] load_seconds_o;
    logic [5:0] load_minutes_o;
    logic [4:0] load_hours_o;
    logic [2:0] state_o;
    logic       blink_o;

    modport slave (
        input  seconds_pulse_i, mode_btn_i, up_btn_i, down_btn_i,
        input  cur_seconds_i, cur_minutes_i, cur_hours_i,
        output tick_o, load_o, load_seconds_o, load_minutes_o, load_hours_o,
        output state_o, blink_o
    );

    modport master (
        output seconds_pulse_i, mode_btn_i, up_btn_i, down_btn_i,
        output cur_seconds_i, cur_minutes_i, cur_hours_i,
        input  tick_o, load_o, load_seconds_o, load_minutes_o, load_hours_o,
        input  state_o, blink_o
    );
endinterface

// File: rtl/clock_set_ctrl.sv
// ---------------------------------------------------------------------------
// clock_set_ctrl
// Time-setting controller for a digital clock. In RUN it forwards each
// seconds edge to the time counter as a one-cycle tick. A mode press copies
// the live time into shadow registers and walks hours -> minutes -> seconds
// editing with up/down; the final mode press loads the shadow time into the
// counter. An edit left untouched for AUTO_EXIT_SECS seconds is abandoned.
//
// Ports:
//   clk_100MHz_i  system clock, all state changes on its rising edge
//   reset_i       asynchronous, active-high reset
//   bus           clock_set_ctrl_if.slave (see interface file for signals)
//
// Parameters:
//   AUTO_EXIT_SECS  seconds without any button edge before an edit aborts
// ---------------------------------------------------------------------------
module clock_set_ctrl #(
    parameter int AUTO_EXIT_SECS = 30
) (
    input  logic                   clk_100MHz_i,
    input  logic                   reset_i,
    clock_set_ctrl_if.slave        bus
);

    localparam logic [2:0] S_RUN    = 3'd0;
    localparam logic [2:0] S_EDIT_H = 3'd1;
    localparam logic [2:0] S_EDIT_M = 3'd2;
    localparam logic [2:0] S_EDIT_S = 3'd3;
    localparam logic [2:0] S_COMMIT = 3'd4;

    localparam int IDLE_W = (AUTO_EXIT_SECS < 1) ? 1 : $clog2(AUTO_EXIT_SECS + 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(AUTO_EXIT_SECS - 1);

    // Increment / decrement with wrap inside [0, maxv]. Anything already
    // above maxv is pulled back into range so the shadows can never escape.
    function automatic logic [5:0] wrap_inc(input logic [5:0] v, input logic [5:0] maxv);
        return (v >= maxv) ? 6'd0 : v + 6'd1;
    endfunction

    function automatic logic [5:0] wrap_dec(input logic [5:0] v, input logic [5:0] maxv);
        return ((v == 6'd0) || (v > maxv)) ? maxv : v - 6'd1;
    endfunction

    // A live value that is out of range (counter glitch) is captured as 0.
    function automatic logic [5:0] sanitize(input logic [5:0] v, input logic [5:0] maxv);
        return (v > maxv) ? 6'd0 : v;
    endfunction

    logic [2:0]        state_q, state_d;
    logic [4:0]        hrs_q, hrs_d;
    logic [5:0]        min_q, min_d;
    logic [5:0]        sec_q, sec_d;
    logic [IDLE_W-1:0] idle_q, idle_d;
    logic              blink_q, blink_d;
    logic              tick_q, tick_d;
    logic              sec_prev_q, mode_prev_q, up_prev_q, down_prev_q;

    logic sec_edge, mode_edge, up_edge, down_edge;
    logic any_btn, step_up, step_dn, in_edit, idle_expire;

    // Edge registers reset to 1 so a level already high at reset release
    // is not mistaken for a fresh press or second.
    assign sec_edge  = bus.seconds_pulse_i & ~sec_prev_q;
    assign mode_edge = bus.mode_btn_i      & ~mode_prev_q;
    assign up_edge   = bus.up_btn_i        & ~up_prev_q;
    assign down_edge = bus.down_btn_i      & ~down_prev_q;

    // Mode beats up/down; simultaneous up and down cancel each other.
    assign step_up = up_edge & ~down_edge & ~mode_edge;
    assign step_dn = down_edge & ~up_edge & ~mode_edge;
    assign any_btn = mode_edge | up_edge | down_edge;

    assign in_edit     = (state_q == S_EDIT_H) || (state_q == S_EDIT_M) ||
                         (state_q == S_EDIT_S);
    // Abort on the second edge that would bring the idle count to the limit.
    assign idle_expire = in_edit && !any_btn && sec_edge && (idle_q == IDLE_LAST);

    always_comb begin
        state_d = state_q;
        hrs_d   = hrs_q;
        min_d   = min_q;
        sec_d   = sec_q;
        idle_d  = idle_q;
        blink_d = blink_q;
        tick_d  = 1'b0;

        case (state_q)
            S_RUN: begin
                tick_d  = sec_edge;
                blink_d = 1'b0;
                idle_d  = '0;
                if (mode_edge) begin
                    hrs_d   = 5'(sanitize({1'b0, bus.cur_hours_i}, 6'd23));
                    min_d   = sanitize(bus.cur_minutes_i, 6'd59);
                    sec_d   = sanitize(bus.cur_seconds_i, 6'd59);
                    state_d = S_EDIT_H;
                    blink_d = 1'b1;
                end
            end

            S_EDIT_H, S_EDIT_M, S_EDIT_S: begin
                if (any_btn) begin
                    idle_d = '0;
                end else if (sec_edge) begin
                    idle_d = idle_q + IDLE_W'(1);
                end
                if (sec_edge) begin
                    blink_d = ~blink_q;
                end

                if (mode_edge) begin
                    case (state_q)
                        S_EDIT_H: state_d = S_EDIT_M;
                        S_EDIT_M: state_d = S_EDIT_S;
                        default: begin
                            state_d = S_COMMIT;
                            blink_d = 1'b0;
                        end
                    endcase
                end else if (idle_expire) begin
                    state_d = S_RUN;
                    idle_d  = '0;
                    blink_d = 1'b0;
                end else begin
                    case (state_q)
                        S_EDIT_H: begin
                            if (step_up) hrs_d = 5'(wrap_inc({1'b0, hrs_q}, 6'd23));
                            if (step_dn) hrs_d = 5'(wrap_dec({1'b0, hrs_q}, 6'd23));
                        end
                        S_EDIT_M: begin
                            if (step_up) min_d = wrap_inc(min_q, 6'd59);
                            if (step_dn) min_d = wrap_dec(min_q, 6'd59);
                        end
                        default: begin
                            if (step_up) sec_d = wrap_inc(sec_q, 6'd59);
                            if (step_dn) sec_d = wrap_dec(sec_q, 6'd59);
                        end
                    endcase
                end
            end

            S_COMMIT: begin
                state_d = S_RUN;
                idle_d  = '0;
                blink_d = 1'b0;
            end

            default: begin
                // Unused encodings fall back to RUN without loading.
                state_d = S_RUN;
                idle_d  = '0;
                blink_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_100MHz_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= S_RUN;
            hrs_q       <= '0;
            min_q       <= '0;
            sec_q       <= '0;
            idle_q      <= '0;
            blink_q     <= 1'b0;
            tick_q      <= 1'b0;
            sec_prev_q  <= 1'b1;
            mode_prev_q <= 1'b1;
            up_prev_q   <= 1'b1;
            down_prev_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            hrs_q       <= hrs_d;
            min_q       <= min_d;
            sec_q       <= sec_d;
            idle_q      <= idle_d;
            blink_q     <= blink_d;
            tick_q      <= tick_d;
            sec_prev_q  <= bus.seconds_pulse_i;
            mode_prev_q <= bus.mode_btn_i;
            up_prev_q   <= bus.up_btn_i;
            down_prev_q <= bus.down_btn_i;
        end
    end

    // COMMIT always lasts exactly one cycle, so load_o is a single strobe.
    assign bus.load_o         = (state_q == S_COMMIT);
    assign bus.tick_o         = tick_q;
    assign bus.load_hours_o   = hrs_q;
    assign bus.load_minutes_o = min_q;
    assign bus.load_seconds_o = sec_q;
    assign bus.state_o        = state_q;
    assign bus.blink_o        = blink_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// ---------------------------------------------------------------------------
// tb_clock_set_ctrl
// Directed bench for clock_set_ctrl. Expected tick_o / load_o events are
// queued when the stimulus is driven and matched cycle by cycle on the
// falling clock edge; state, shadow and blink values are checked inline.
// ---------------------------------------------------------------------------
module tb_clock_set_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   tick_seen = 0;
    int   load_seen = 0;

    typedef struct {
        int cyc;
        int h;
        int m;
        int s;
    } load_exp_t;

    int        tq[$];
    load_exp_t lq[$];

    clock_set_ctrl_if bus();

    clock_set_ctrl #(.AUTO_EXIT_SECS(30)) dut (
        .clk_100MHz_i (clk),
        .reset_i      (rst),
        .bus          (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Scoreboard: every cycle, tick_o and load_o must match the queued events.
    always @(negedge clk) begin
        logic exp_t;
        logic exp_l;
        exp_t = (tq.size() > 0) && (tq[0] == cyc);
        chk("tick_o", bus.tick_o, exp_t);
        if (exp_t) void'(tq.pop_front());
        if (bus.tick_o === 1'b1) tick_seen++;

        exp_l = (lq.size() > 0) && (lq[0].cyc == cyc);
        chk("load_o", bus.load_o, exp_l);
        if (exp_l) begin
            chk("load_hours", bus.load_hours_o, lq[0].h);
            chk("load_minutes", bus.load_minutes_o, lq[0].m);
            chk("load_seconds", bus.load_seconds_o, lq[0].s);
            void'(lq.pop_front());
        end
        if (bus.load_o === 1'b1) load_seen++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic m, input logic u, input logic d);
        bus.mode_btn_i = m;
        bus.up_btn_i   = u;
        bus.down_btn_i = d;
        step();
        bus.mode_btn_i = 1'b0;
        bus.up_btn_i   = 1'b0;
        bus.down_btn_i = 1'b0;
        step();
    endtask

    task automatic sec_edge(input bit expect_tick);
        bus.seconds_pulse_i = 1'b1;
        if (expect_tick) tq.push_back(cyc + 1);
        repeat (3) step();
        bus.seconds_pulse_i = 1'b0;
        repeat (3) step();
    endtask

    task automatic push_load(input int h, input int m, input int s);
        load_exp_t e;
        e.cyc = cyc + 1;
        e.h = h;
        e.m = m;
        e.s = s;
        lq.push_back(e);
    endtask

    task automatic set_cur(input int h, input int m, input int s);
        bus.cur_hours_i   = 5'(h);
        bus.cur_minutes_i = 6'(m);
        bus.cur_seconds_i = 6'(s);
    endtask

    task automatic chk_outputs_idle(input string tag);
        chk({tag, "_state"}, bus.state_o, 0);
        chk({tag, "_tick"}, bus.tick_o, 0);
        chk({tag, "_load"}, bus.load_o, 0);
        chk({tag, "_blink"}, bus.blink_o, 0);
        chk({tag, "_lh"}, bus.load_hours_o, 0);
        chk({tag, "_lm"}, bus.load_minutes_o, 0);
        chk({tag, "_ls"}, bus.load_seconds_o, 0);
    endtask

    initial begin
        bus.seconds_pulse_i = 1'b0;
        bus.mode_btn_i      = 1'b0;
        bus.up_btn_i        = 1'b0;
        bus.down_btn_i      = 1'b0;
        set_cur(23, 59, 58);

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk_outputs_idle("reset");
        rst = 1'b0;
        step();

        // Four seconds edges in RUN give four ticks
        for (int i = 0; i < 4; i++) sec_edge(1'b1);
        chk("tick_count_run", tick_seen, 4);

        // Full edit with wraps: 23:59:58 -> 00:58:59
        press(1'b1, 1'b0, 1'b0);
        chk("enter_state", bus.state_o, 1);
        chk("enter_blink", bus.blink_o, 1);
        chk("cap_h", bus.load_hours_o, 23);
        chk("cap_m", bus.load_minutes_o, 59);
        chk("cap_s", bus.load_seconds_o, 58);
        press(1'b0, 1'b1, 1'b0);
        chk("hour_wrap_up", bus.load_hours_o, 0);
        press(1'b1, 1'b0, 1'b0);
        chk("edit_m_state", bus.state_o, 2);
        press(1'b0, 1'b0, 1'b1);
        chk("min_down", bus.load_minutes_o, 58);
        press(1'b1, 1'b0, 1'b0);
        chk("edit_s_state", bus.state_o, 3);
        press(1'b0, 1'b1, 1'b0);
        chk("sec_up", bus.load_seconds_o, 59);
        push_load(0, 58, 59);
        press(1'b1, 1'b0, 1'b0);
        chk("after_commit_state", bus.state_o, 0);
        chk("after_commit_blink", bus.blink_o, 0);

        // Simultaneous buttons: up+down cancel, mode beats up
        press(1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b0, 1'b1);
        chk("hour_down", bus.load_hours_o, 22);
        press(1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b1, 1'b0);
        chk("min_wrap_up", bus.load_minutes_o, 0);
        press(1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b1, 1'b1);
        chk("updown_state", bus.state_o, 3);
        chk("updown_sec", bus.load_seconds_o, 58);
        push_load(22, 0, 58);
        bus.mode_btn_i = 1'b1;
        bus.up_btn_i   = 1'b1;
        step();
        chk("mode_up_state", bus.state_o, 4);
        chk("mode_up_sec", bus.load_seconds_o, 58);
        bus.mode_btn_i = 1'b0;
        bus.up_btn_i   = 1'b0;
        step();
        chk("mode_up_run", bus.state_o, 0);

        // Down wraps at zero, then idle timeout aborts without load or tick
        set_cur(0, 0, 0);
        press(1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b0, 1'b1);
        chk("hour_wrap_down", bus.load_hours_o, 23);
        press(1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b0, 1'b1);
        chk("min_wrap_down", bus.load_minutes_o, 59);
        sec_edge(1'b0);
        chk("blink_toggle", bus.blink_o, 0);
        sec_edge(1'b0);
        chk("blink_toggle2", bus.blink_o, 1);
        for (int i = 2; i < 29; i++) sec_edge(1'b0);
        chk("idle29_state", bus.state_o, 2);
        sec_edge(1'b0);
        chk("idle30_state", bus.state_o, 0);
        chk("idle30_blink", bus.blink_o, 0);
        chk("idle_no_tick", tick_seen, 4);
        chk("idle_no_load", load_seen, 2);

        // Reset mid-edit with the seconds level held high
        set_cur(12, 34, 56);
        press(1'b1, 1'b0, 1'b0);
        press(1'b1, 1'b0, 1'b0);
        chk("pre_reset_state", bus.state_o, 2);
        bus.seconds_pulse_i = 1'b1;
        step();
        rst = 1'b1;
        #2;
        chk_outputs_idle("midedit_reset");
        step();
        step();
        rst = 1'b0;
        repeat (5) step();
        chk("post_reset_state", bus.state_o, 0);
        chk("post_reset_no_tick", tick_seen, 4);
        bus.seconds_pulse_i = 1'b0;
        step();
        step();
        sec_edge(1'b1);
        chk("fresh_tick", tick_seen, 5);

        // Nothing left outstanding
        repeat (3) step();
        chk("tick_queue_empty", tq.size(), 0);
        chk("load_queue_empty", lq.size(), 0);
        chk("load_total", load_seen, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
